// File: rtl/toy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toy_pkg
// Description : Shared access-size codes, MEM-stage FSM states and lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package toy_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Reserved size 2'b11 behaves as a word everywhere below.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  is_aligned = 1'b1;
            SIZE_H:  is_aligned = ~off[0];
            default: is_aligned = (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  byte_en = 4'b0001 << off;
            SIZE_H:  byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rs2);
        case (size)
            SIZE_B:  store_data = {4{rs2[7:0]}};
            SIZE_H:  store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed load lane and sign/zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import toy_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);

    logic [31:0] w_shift;
    logic        w_sign;

    always_comb begin
        w_shift  = i_rdata >> {i_addr_lo, 3'b000};
        w_sign   = 1'b0;
        o_result = i_rdata;
        case (i_size)
            SIZE_B: begin
                w_sign   = ~i_unsigned & w_shift[7];
                o_result = {{24{w_sign}}, w_shift[7:0]};
            end
            SIZE_H: begin
                w_sign   = ~i_unsigned & w_shift[15];
                o_result = {{16{w_sign}}, w_shift[15:0]};
            end
            default: o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM-stage load/store unit with valid/ack bus, stall and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import toy_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  Size_M,
    input  logic        Unsigned_M,
    input  logic [31:0] ALUOUT_M,
    input  logic [31:0] DOUT1_M,
    output logic        DREQ,
    output logic        DWE,
    output logic [31:0] DADDR,
    output logic [3:0]  DBE,
    output logic [31:0] DWDATA,
    input  logic [31:0] DRDATA,
    input  logic        DACK,
    output logic [31:0] LoadData_M,
    output logic        STALL_M,
    output logic        MISALIGN_M,
    output logic        BUSERR_M
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic             c_TO_EN   = (TIMEOUT != 0);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic              w_active, w_aligned, w_timeout, w_req;
    logic [31:0]       w_load;

    load_align u_load_align (
        .i_addr_lo  (ALUOUT_M[1:0]),
        .i_size     (Size_M),
        .i_unsigned (Unsigned_M),
        .i_rdata    (DRDATA),
        .o_result   (w_load)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_active  = MemRead_M | MemWrite_M;
        w_aligned = is_aligned(Size_M, ALUOUT_M[1:0]);
        // An ack in the expiry cycle still completes the access normally.
        w_timeout = (r_state == ST_WAIT) && c_TO_EN && (r_cnt == c_TIMEOUT) && !DACK;
        w_req     = !RST && w_active && w_aligned && !w_timeout;

        DREQ       = w_req;
        DWE        = w_req & MemWrite_M;
        DADDR      = w_req ? {ALUOUT_M[31:2], 2'b00} : 32'h0;
        DBE        = w_req ? byte_en(Size_M, ALUOUT_M[1:0]) : 4'h0;
        DWDATA     = w_req ? store_data(Size_M, DOUT1_M) : 32'h0;
        STALL_M    = w_req & !DACK;
        MISALIGN_M = !RST && w_active && !w_aligned;
        BUSERR_M   = !RST && w_timeout;
        LoadData_M = (w_req && DACK && MemRead_M) ? w_load : 32'h0;

        w_state_nxt = STALL_M ? ST_WAIT : ST_IDLE;
        w_cnt_nxt   = (r_state == ST_WAIT && STALL_M) ? r_cnt + 1'b1 : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Randomized scoreboard bench for mem_access (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MemRead_M = 1'b0, MemWrite_M = 1'b0, Unsigned_M = 1'b0, DACK = 1'b0;
    logic [1:0]  Size_M = 2'b00;
    logic [31:0] ALUOUT_M = '0, DOUT1_M = '0, DRDATA = '0;
    logic        DREQ, DWE, STALL_M, MISALIGN_M, BUSERR_M;
    logic [31:0] DADDR, DWDATA, LoadData_M;
    logic [3:0]  DBE;

    always #5 CLK = ~CLK;

    mem_access #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .Size_M(Size_M), .Unsigned_M(Unsigned_M), .ALUOUT_M(ALUOUT_M), .DOUT1_M(DOUT1_M),
        .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DBE(DBE), .DWDATA(DWDATA),
        .DRDATA(DRDATA), .DACK(DACK), .LoadData_M(LoadData_M), .STALL_M(STALL_M),
        .MISALIGN_M(MISALIGN_M), .BUSERR_M(BUSERR_M)
    );

    typedef enum int {K_DONE, K_MIS, K_BERR, K_ABANDON} kind_e;
    typedef struct {
        kind_e       kind;
        int          stalls;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chk_wd;
        logic [31:0] wd;
        logic [31:0] ld;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per completion / misalign / bus-error event.
    always @(negedge CLK) begin
        if (RST) begin
            stall_run = 0;
            if (q.size() > 0 && q[0].kind == K_ABANDON) begin
                chk("abandon_dreq", 32'(DREQ), 32'h0);
                chk("abandon_stall", 32'(STALL_M), 32'h0);
                void'(q.pop_front());
            end else begin
                chk("rst_ctrl", 32'({DREQ, DWE, STALL_M, MISALIGN_M, BUSERR_M, DBE}), 32'h0);
                chk("rst_data", DADDR | DWDATA | LoadData_M, 32'h0);
            end
        end else if ((DREQ && DACK) || MISALIGN_M || BUSERR_M) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got event with empty queue at %0t", $time);
            end else begin
                m_e = q.pop_front();
                chk("stall_cycles", stall_run, m_e.stalls);
                chk("stall_end", 32'(STALL_M), 32'h0);
                case (m_e.kind)
                    K_DONE: begin
                        chk("done_flags", 32'({DREQ, MISALIGN_M, BUSERR_M}), 32'b100);
                        chk("done_addr", DADDR, m_e.addr);
                        chk("done_be", 32'(DBE), 32'(m_e.be));
                        chk("done_we", 32'(DWE), 32'(m_e.we));
                        if (m_e.chk_wd) chk("done_wdata", DWDATA, m_e.wd);
                        chk("done_load", LoadData_M, m_e.ld);
                    end
                    K_MIS: begin
                        chk("mis_flags", 32'({DREQ, MISALIGN_M, BUSERR_M}), 32'b010);
                        chk("mis_be", 32'(DBE), 32'h0);
                        chk("mis_load", LoadData_M, 32'h0);
                    end
                    K_BERR: begin
                        chk("berr_flags", 32'({DREQ, MISALIGN_M, BUSERR_M}), 32'b001);
                        chk("berr_load", LoadData_M, 32'h0);
                    end
                    default: begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL abandon_event: got bus event expected reset at %0t", $time);
                    end
                endcase
            end
            stall_run = 0;
        end else if (STALL_M) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_stall: got stall with empty queue at %0t", $time);
            end else begin
                chk("hold_addr", DADDR, q[0].addr);
                chk("hold_be", 32'(DBE), 32'(q[0].be));
                chk("hold_we", 32'(DWE), 32'(q[0].we));
                if (q[0].chk_wd) chk("hold_wdata", DWDATA, q[0].wd);
                chk("hold_load", LoadData_M, 32'h0);
            end
            stall_run++;
        end else begin
            chk("idle_dreq", 32'(DREQ), 32'h0);
            chk("idle_load", LoadData_M, 32'h0);
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t model(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] rs2, input logic [31:0] rdata, input int lat);
        exp_t        e;
        int          bytes, off;
        logic [31:0] mask, v;
        bytes    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        off      = int'(addr % 4);
        e.addr   = {addr[31:2], 2'b00};
        e.we     = wr;
        e.be     = 4'(((1 << bytes) - 1) << off);
        e.chk_wd = wr;
        e.wd     = (bytes == 1) ? 32'(rs2[7:0]) * 32'h0101_0101 :
                   (bytes == 2) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
        mask     = (bytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * bytes)) - 32'h1;
        v        = (rdata >> (8 * off)) & mask;
        if (!uns && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
        e.ld     = rd ? v : 32'h0;
        if (off % bytes != 0) begin
            e.kind = K_MIS; e.stalls = 0; e.ld = 32'h0;
        end else if (lat <= TO + 1) begin
            e.kind = K_DONE; e.stalls = lat;
        end else begin
            e.kind = K_BERR; e.stalls = TO + 1; e.ld = 32'h0;
        end
        return e;
    endfunction

    // Drives one access for exactly as many cycles as the model says it takes.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int lat);
        exp_t e;
        int   n;
        e = model(rd, wr, sz, uns, addr, rs2, rdata, lat);
        MemRead_M = rd; MemWrite_M = wr; Size_M = sz; Unsigned_M = uns;
        ALUOUT_M = addr; DOUT1_M = rs2;
        q.push_back(e);
        n = (e.kind == K_MIS) ? 1 : (e.kind == K_DONE) ? lat + 1 : TO + 2;
        for (int c = 0; c < n; c++) begin
            if (e.kind == K_MIS) DACK = 1'($urandom_range(0, 1));
            else                 DACK = (e.kind == K_DONE && c == lat);
            DRDATA = DACK ? rdata : $urandom;
            next_cycle();
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            MemRead_M = 1'b0; MemWrite_M = 1'b0;
            Size_M = 2'($urandom_range(0, 3)); ALUOUT_M = $urandom; DOUT1_M = $urandom;
            DACK = 1'($urandom_range(0, 1)); DRDATA = $urandom;
            next_cycle();
        end
    endtask

    // Word load that never gets an ack; reset lands in its second WAIT cycle.
    task automatic abandon(input logic [31:0] addr);
        exp_t e;
        e = model(1'b1, 1'b0, 2'b10, 1'b0, addr, 32'h0, 32'h0, 0);
        e.kind = K_ABANDON;
        MemRead_M = 1'b1; MemWrite_M = 1'b0; Size_M = 2'b10; Unsigned_M = 1'b0;
        ALUOUT_M = addr; DACK = 1'b0; DRDATA = $urandom;
        q.push_back(e);
        next_cycle();
        next_cycle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;
        int          lat;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hABCD_5678, 32'h0, 3);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0, 32'h1234_5678, 0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 99);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, TO + 1);
        abandon(32'h0000_4000);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 1);
        idle(2);
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h0000_9ABC, 0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 32'h1357_9BDF, 0);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle(int'($urandom_range(1, 2)));
            end else begin
                sz   = 2'($urandom_range(0, 3));
                addr = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'b01)      addr[0] = 1'b0;
                    else if (sz != 2'b00) addr[1:0] = 2'b00;
                end
                lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 8))
                                                  : int'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1)
                    access(1'b1, 1'b0, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom, lat);
                else
                    access(1'b0, 1'b1, sz, 1'b0, addr, $urandom, $urandom, lat);
            end
        end

        idle(3);
        for (int w = 0; w < 20 && q.size() > 0; w++) next_cycle();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-stage load/store unit of the RISC toy pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register (MW). It issues data-memory requests over a valid/ack handshake and stalls the pipeline while memory is slow. It aligns store data, generates byte enables, sign- or zero-extends load data into `LoadData_M`, and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, default 255: WAIT-state cycles before bus error; 0 disables the timeout.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `MemRead_M`  in  1  load in the MEM stage.
- `MemWrite_M`  in  1  store in the MEM stage. Never asserted together with `MemRead_M`.
- `Size_M`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `Unsigned_M`  in  1  zero-extend loads when set, sign-extend when clear.
- `ALUOUT_M`  in  32  effective address.
- `DOUT1_M`  in  32  store data (rs2).
- `DREQ`  out  1  memory request valid.
- `DWE`  out  1  write request.
- `DADDR`  out  32  word-aligned address {`ALUOUT_M`[31:2], 2'b00}.
- `DBE`  out  4  byte enables.
- `DWDATA`  out  32  lane-replicated store data.
- `DRDATA`  in  32  read data, valid when `DACK`=1.
- `DACK`  in  1  request completes this cycle.
- `LoadData_M`  out  32  extended load result, to MW.
- `STALL_M`  out  1  freezes PC/IF/ID/EX/EM and holds MW.
- `MISALIGN_M`  out  1  misaligned access this cycle.
- `BUSERR_M`  out  1  one-cycle pulse on timeout.

## Operation
- FSM states: IDLE, WAIT.
- Access is active when `MemRead_M | MemWrite_M`.
- Alignment:
  - Half is aligned when addr[0]=0.
  - Word is aligned when addr[1:0]=0.
  - Byte is always aligned.
- Misaligned access: `MISALIGN_M`=1 and `DREQ`=0 that cycle. `LoadData_M`=0, no stall, state stays IDLE. Stores are suppressed.
- Byte enables (`DBE`):
  - byte: 1<<addr[1:0].
  - half: 4'b0011 or 4'b1100 by addr[1].
  - word: 4'b1111.
  - Loads drive the same `DBE` pattern. `DBE`=0 whenever `DREQ`=0.
- Store data (`DWDATA`):
  - byte: {4{rs2[7:0]}}.
  - half: {2{rs2[15:0]}}.
  - word: rs2.
- Load data: select the lane by addr and size, then extend to 32 bits.
  - Extension uses bit 7 or 15 of the selected lane unless `Unsigned_M`=1.
- IDLE:
  - On an aligned access, assert `DREQ`, and `DWE`=`MemWrite_M`.
  - `DACK`=1 the same cycle: done. `STALL_M`=0, `LoadData_M` valid, stay in IDLE.
  - Else: `STALL_M`=1, go to WAIT, counter cleared to 0.
- WAIT:
  - `DREQ` stays high; `DADDR`, `DWE`, `DBE` and `DWDATA` stay stable, because upstream is frozen by the stall.
  - `DACK`=1: `STALL_M`=0, `LoadData_M` valid, go to IDLE.
  - Otherwise the counter increments.
  - When the counter reaches `TIMEOUT` (and `TIMEOUT`≠0) with no `DACK`:
    - `DREQ`=0, `BUSERR_M`=1, `STALL_M`=0, `LoadData_M`=0, go to IDLE.
    - `DACK` arriving in that same cycle wins: normal completion, no `BUSERR_M`.
- `LoadData_M`=0 whenever no load completes this cycle.

## Timing
- Reset value of every output is 0:
  - While `RST`=1: state=IDLE, counter=0, and all outputs forced to 0, including `DREQ` and `STALL_M`.
  - Reset asserted mid-WAIT abandons the request: `DREQ` drops the same cycle.
- Zero-wait memory (`DACK` in the request cycle): 0-cycle added latency, never stalls.
- N-cycle memory: `STALL_M` high for exactly N cycles. Data is captured by MW on the edge that ends the `DACK` cycle.
- All outputs are combinational from state, counter and inputs. Only the state and counter (8 bits, wide enough for `TIMEOUT`) are registered.
- Back-to-back accesses: a new request may start in the cycle after `DACK`, with no idle bubble.
- `DACK` while `DREQ`=0: ignored.

## Structure
- Shared package `toy_pkg` holds:
  - `SIZE_B`=2'b00, `SIZE_H`=2'b01, `SIZE_W`=2'b10.
  - FSM state encodings `ST_IDLE`, `ST_WAIT`.
- Sub-module `load_align`: combinational lane select and extension (addr[1:0], size, unsigned, rdata → 32-bit result).

## Test plan
- Zero-wait load: `lb` at 0x1003, `DRDATA`=0x80FF_1234, `DACK` same cycle → `DBE`=4'b1000, `LoadData_M`=0xFFFF_FF80, `STALL_M`=0.
- Store with wait states: `sh` at 0x2002, rs2=0xABCD_5678, `DACK` after 3 cycles:
  - `DBE`=4'b1100, `DWDATA`=0x5678_5678.
  - `STALL_M` high exactly 3 cycles; bus held stable throughout.
- Misaligned word load at 0x1001 → `MISALIGN_M`=1, `DREQ`=0, `LoadData_M`=0, no stall.
- Timeout with `TIMEOUT`=4, `DACK` never arrives → `BUSERR_M` pulses once in the 5th cycle, then `STALL_M`=0.
  - Repeat with `DACK` in that same cycle → normal completion, no `BUSERR_M`.
- Reset mid-WAIT: assert `RST` in the 2nd wait cycle → `DREQ` and `STALL_M` are 0 the same cycle. The next load completes normally.
- Unsigned half load (`lhu`) at 0x0, `DRDATA`=0x0000_9ABC, followed by a back-to-back word load → `LoadData_M`=0x0000_9ABC, then the word value, no bubble.
